// File: rtl/link_stats_pkg.sv
// Shared constants and helpers for the link statistics histogram.
// CSR bit positions, clear-sequencer states and clog2.
package link_stats_pkg;

  localparam int CSR_CLR_BIT  = 31;
  localparam int CSR_DROP_BIT = 30;
  localparam int CSR_ADDR_LSB = 1;
  localparam int CSR_WSEL_BIT = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SWEEP = 2'd2
  } clr_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/link_stats_histogram_if.sv
// Event, CSR and readback signals of the link statistics histogram.
// The monitor side is the master, the histogram the slave.
interface link_stats_histogram_if #(
  parameter int NCHAN      = 5,
  parameter int CODE_WIDTH = 2
);
  logic [NCHAN-1:0]            evStrobe;
  logic [NCHAN*CODE_WIDTH-1:0] evCode;
  logic                        sysCsrStrobe;
  logic [31:0]                 GPIO_OUT;
  logic [31:0]                 sysValue;
  logic                        busy;

  modport master (
    output evStrobe, evCode, sysCsrStrobe, GPIO_OUT,
    input  sysValue, busy
  );

  modport slave (
    input  evStrobe, evCode, sysCsrStrobe, GPIO_OUT,
    output sysValue, busy
  );
endinterface

// File: rtl/link_stats_dpram.sv
// Histogram bin storage: one write port, two synchronous read ports.
// Reads return the old word on a same-edge write.
module link_stats_dpram
  import link_stats_pkg::*;
#(
  parameter int AW = 5,
  parameter int DW = 48
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr_a,
  output logic [DW-1:0] o_rdata_a,
  input  logic [AW-1:0] i_raddr_b,
  output logic [DW-1:0] o_rdata_b
);
  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata_a <= r_mem[i_raddr_a];
    o_rdata_b <= r_mem[i_raddr_b];
  end
endmodule

// File: rtl/link_stats_histogram.sv
// Per-channel event histogram: round-robin arbiter + 3-stage RMW.
// Define LINK_STATS_SATURATE_EN to make bins stick at all-ones.
module link_stats_histogram
  import link_stats_pkg::*;
#(
  parameter int NCHAN       = 5,
  parameter int CODE_WIDTH  = 2,
  parameter int COUNT_WIDTH = 48
) (
  input  logic sysClk,
  input  logic sysReset,
  link_stats_histogram_if.slave io
);
  localparam int CHW = (clog2(NCHAN) < 1) ? 1 : clog2(NCHAN);
  localparam int AW  = CHW + CODE_WIDTH;
  localparam int CW  = COUNT_WIDTH;

  typedef logic [AW-1:0] addr_t;
  typedef logic [CW-1:0] bin_t;

  clr_state_t r_state, w_state_nxt;
  addr_t      r_sweep;
  logic       w_busy, w_idle, w_clr_req, w_sweep_done;

  logic [NCHAN-1:0]                 w_stb, w_gnt_oh;
  logic [NCHAN-1:0]                 r_pend_v;
  logic [NCHAN-1:0][CODE_WIDTH-1:0] r_pend_code;
  logic [CHW-1:0]                   r_ptr, w_gnt_ch;
  logic [CODE_WIDTH-1:0]            w_gnt_code;
  logic                             w_gnt_v;
  addr_t                            w_gnt_addr;

  logic  r_s1_v, r_s2_v, r_s3_v;
  addr_t r_s1_addr, r_s2_addr, r_s3_addr;
  bin_t  r_s2_val, r_s3_val;
  bin_t  w_rdata, w_rdata_b, w_fwd, w_inc;

  logic        w_we;
  addr_t       w_waddr;
  bin_t        w_wdata;
  logic [15:0] r_drop, w_drop_nxt;
  logic [16:0] w_drop_sum;

  addr_t       r_rd_addr;
  logic        r_wsel, r_dsel;
  logic [31:0] r_value, w_value;
  logic        w_unused;

  assign w_stb        = io.evStrobe;
  assign w_busy       = (r_state == ST_SWEEP);
  assign w_idle       = (r_state == ST_IDLE);
  assign w_clr_req    = io.sysCsrStrobe & io.GPIO_OUT[CSR_CLR_BIT];
  assign w_sweep_done = w_busy && (r_sweep == '1);
  assign w_gnt_addr   = {w_gnt_ch, w_gnt_code};
  assign w_unused     = ^io.GPIO_OUT[29:AW+1];
  assign io.busy      = w_busy;
  assign io.sysValue  = r_value;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_clr_req) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (!r_s1_v && !r_s2_v) w_state_nxt = ST_SWEEP;
      ST_SWEEP: if (r_sweep == '1) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Reset lands in DRAIN so every reset release runs a full sweep.
  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      r_state <= ST_DRAIN;
      r_sweep <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sweep <= w_busy ? r_sweep + 1'b1 : '0;
    end
  end

  always_comb begin
    w_gnt_v    = 1'b0;
    w_gnt_ch   = '0;
    w_gnt_code = '0;
    for (int i = 0; i < NCHAN; i++)
      if (!w_gnt_v && r_pend_v[i] && (CHW'(i) >= r_ptr)) begin
        w_gnt_v    = 1'b1;
        w_gnt_ch   = CHW'(i);
        w_gnt_code = r_pend_code[i];
      end
    for (int i = 0; i < NCHAN; i++)
      if (!w_gnt_v && r_pend_v[i]) begin
        w_gnt_v    = 1'b1;
        w_gnt_ch   = CHW'(i);
        w_gnt_code = r_pend_code[i];
      end
    if (!w_idle) w_gnt_v = 1'b0;
  end

  always_comb begin
    w_gnt_oh   = '0;
    w_drop_sum = {1'b0, r_drop};
    for (int i = 0; i < NCHAN; i++) begin
      w_gnt_oh[i] = w_gnt_v && (w_gnt_ch == CHW'(i));
      w_drop_sum  = w_drop_sum +
        17'(w_stb[i] & r_pend_v[i] & ~w_gnt_oh[i]);
    end
    w_drop_nxt = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
  end

  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      r_pend_v    <= '0;
      r_pend_code <= '0;
      r_ptr       <= '0;
      r_drop      <= '0;
    end else begin
      for (int i = 0; i < NCHAN; i++) begin
        if (w_stb[i] && (!r_pend_v[i] || w_gnt_oh[i])) begin
          r_pend_v[i]    <= 1'b1;
          r_pend_code[i] <= io.evCode[i*CODE_WIDTH +: CODE_WIDTH];
        end else if (w_gnt_oh[i]) begin
          r_pend_v[i] <= 1'b0;
        end
      end
      if (w_gnt_v)
        r_ptr <= (w_gnt_ch == CHW'(NCHAN-1)) ? '0 : w_gnt_ch + 1'b1;
      r_drop <= w_sweep_done ? '0 : w_drop_nxt;
    end
  end

  // s2 is about to be written, s3 was written on the last edge.
  always_comb begin
    w_fwd = w_rdata;
    if (r_s3_v && (r_s3_addr == r_s1_addr)) w_fwd = r_s3_val;
    if (r_s2_v && (r_s2_addr == r_s1_addr)) w_fwd = r_s2_val;
`ifdef LINK_STATS_SATURATE_EN
    w_inc = (&w_fwd) ? w_fwd : w_fwd + bin_t'(1);
`else
    w_inc = w_fwd + bin_t'(1);
`endif
  end

  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      r_s1_v    <= 1'b0;
      r_s2_v    <= 1'b0;
      r_s3_v    <= 1'b0;
      r_s1_addr <= '0;
      r_s2_addr <= '0;
      r_s3_addr <= '0;
      r_s2_val  <= '0;
      r_s3_val  <= '0;
    end else begin
      r_s1_v    <= w_gnt_v;
      r_s1_addr <= w_gnt_addr;
      r_s2_v    <= r_s1_v;
      r_s2_addr <= r_s1_addr;
      r_s2_val  <= w_inc;
      r_s3_v    <= r_s2_v;
      r_s3_addr <= r_s2_addr;
      r_s3_val  <= r_s2_val;
    end
  end

  assign w_we    = w_busy | r_s2_v;
  assign w_waddr = w_busy ? r_sweep : r_s2_addr;
  assign w_wdata = w_busy ? '0 : r_s2_val;

  link_stats_dpram #(.AW(AW), .DW(CW)) u_ram (
    .i_clk     (sysClk),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a (w_gnt_addr),
    .o_rdata_a (w_rdata),
    .i_raddr_b (r_rd_addr),
    .o_rdata_b (w_rdata_b)
  );

  always_comb begin
    w_value = w_rdata_b[31:0];
    if (r_wsel) w_value = 32'(w_rdata_b >> 32);
    if (int'(r_rd_addr[AW-1 -: CHW]) >= NCHAN) w_value = '0;
    if (r_dsel) w_value = {16'h0, r_drop};
  end

  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      r_rd_addr <= '0;
      r_wsel    <= 1'b0;
      r_dsel    <= 1'b0;
      r_value   <= '0;
    end else begin
      if (io.sysCsrStrobe) begin
        r_rd_addr <= io.GPIO_OUT[CSR_ADDR_LSB +: AW];
        r_wsel    <= io.GPIO_OUT[CSR_WSEL_BIT];
        r_dsel    <= io.GPIO_OUT[CSR_DROP_BIT];
      end
      r_value <= w_value;
    end
  end
endmodule

// File: tb/tb_link_stats_histogram.sv
// Directed bench for link_stats_histogram (NCHAN=5, CODE_WIDTH=2).
// Bin index is ch*4+code; channels 5..7 (bins 20..31) are unused.
module tb_link_stats_histogram;
  localparam int NCH  = 5;
  localparam int CWD  = 2;
  localparam int CNTW = 48;
  localparam int NBIN = 32;
`ifdef LINK_STATS_SATURATE_EN
  localparam logic [47:0] SAT_EXP = 48'hFFFF_FFFF_FFFF;
`else
  localparam logic [47:0] SAT_EXP = 48'h0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  link_stats_histogram_if #(.NCHAN(NCH), .CODE_WIDTH(CWD)) bus ();

  link_stats_histogram #(
    .NCHAN(NCH), .CODE_WIDTH(CWD), .COUNT_WIDTH(CNTW)
  ) dut (
    .sysClk   (clk),
    .sysReset (rst),
    .io       (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic csr(input logic clr, input logic dsel,
                     input logic [4:0] a, input logic wsel);
    logic [31:0] w;
    w     = '0;
    w[31] = clr;
    w[30] = dsel;
    w[5:1] = a;
    w[0]  = wsel;
    bus.GPIO_OUT     = w;
    bus.sysCsrStrobe = 1'b1;
    tick();
    bus.sysCsrStrobe = 1'b0;
  endtask

  task automatic rd(input logic dsel, input logic [4:0] a,
                    input logic wsel, output logic [31:0] v);
    csr(1'b0, dsel, a, wsel);
    tick(3);
    v = bus.sysValue;
  endtask

  task automatic rd_bin(input logic [4:0] a, output logic [47:0] v);
    logic [31:0] lo, hi;
    rd(1'b0, a, 1'b0, lo);
    rd(1'b0, a, 1'b1, hi);
    v = {hi[15:0], lo};
  endtask

  task automatic rd_drop(output logic [31:0] v);
    rd(1'b1, 5'd0, 1'b0, v);
  endtask

  task automatic bins_sum(output longint s, output int nz);
    logic [47:0] v;
    s  = 0;
    nz = 0;
    for (int a = 0; a < NBIN; a++) begin
      rd_bin(5'(a), v);
      s += longint'(v);
      if (v != 0) nz++;
    end
  endtask

  task automatic wait_busy(input string tag, input int exp_len);
    int t, len;
    t = 0;
    while (!bus.busy && t < 20) begin
      tick();
      t++;
    end
    chk({tag, "_rise"}, 64'(bus.busy), 64'd1);
    len = 0;
    while (bus.busy && len < 200) begin
      tick();
      len++;
    end
    chk({tag, "_len"}, 64'(len), 64'(exp_len));
  endtask

  task automatic pulse(input logic [4:0] stb, input logic [9:0] code,
                       input int n, input int gap);
    repeat (n) begin
      bus.evStrobe = stb;
      bus.evCode   = code;
      tick();
      bus.evStrobe = '0;
      tick(gap);
    end
  endtask

  initial begin
    logic [47:0] v;
    logic [31:0] w, d;
    longint      s, s5;
    int          nz;

    bus.evStrobe     = '0;
    bus.evCode       = '0;
    bus.sysCsrStrobe = 1'b0;
    bus.GPIO_OUT     = '0;
    tick(3);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_value", 64'(bus.sysValue), 64'd0);
    rst = 1'b0;
    wait_busy("sweep0", NBIN);

    dut.u_ram.r_mem[9]  <= 48'h0000_1111_2222;
    dut.u_ram.r_mem[25] <= 48'h0000_0000_ABCD;
    dut.u_ram.r_mem[3]  <= 48'h7;
    tick();
    rd_bin(5'd9, v);
    chk("bd_bin9", 64'(v), 64'h1111_2222);
    rd(1'b0, 5'd25, 1'b0, w);
    chk("unused_ch", 64'(w), 64'd0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(10);
    chk("mid_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_busy("sweep_abort", NBIN);
    bins_sum(s, nz);
    chk("clr_sum", 64'(s), 64'd0);
    chk("clr_nz", 64'(nz), 64'd0);
    rd_drop(d);
    chk("clr_drop", 64'(d), 64'd0);

    pulse(5'b00100, 10'h010, 10, 1);
    tick(5);
    rd_bin(5'd9, v);
    chk("t34_bin", 64'(v), 64'd10);
    bins_sum(s, nz);
    chk("t34_sum", 64'(s), 64'd10);

    bus.evCode   = 10'h003;
    bus.evStrobe = 5'b00001;
    tick(50);
    bus.evStrobe = '0;
    tick(5);
    rd_bin(5'd3, v);
    chk("t36_bin", 64'(v), 64'd50);
    rd_drop(d);
    chk("t36_drop", 64'(d), 64'd0);

    bus.evCode   = 10'h0E4;
    bus.evStrobe = 5'h1F;
    tick(100);
    bus.evStrobe = '0;
    tick(10);
    s5 = 0;
    rd_bin(5'd0, v);  s5 += longint'(v);
    rd_bin(5'd5, v);  s5 += longint'(v);
    rd_bin(5'd10, v); s5 += longint'(v);
    rd_bin(5'd15, v); s5 += longint'(v);
    rd_bin(5'd16, v); s5 += longint'(v);
    rd_drop(d);
    chk("t35_drop", 64'(d), 64'd396);
    chk("t35_total", 64'(s5 + longint'(d)), 64'd500);
    bins_sum(s, nz);
    chk("t35_all", 64'(s), 64'd164);

    bus.evCode   = 10'h008;
    bus.evStrobe = 5'b01010;
    tick(5);
    csr(1'b1, 1'b0, 5'd0, 1'b0);
    tick(1);
    bus.evStrobe = '0;
    wait_busy("t37", NBIN);
    tick(5);
    rd_bin(5'd6, v);
    chk("t37_bin6", 64'(v), 64'd1);
    rd_bin(5'd12, v);
    chk("t37_bin12", 64'(v), 64'd1);
    bins_sum(s, nz);
    chk("t37_sum", 64'(s), 64'd2);
    rd_drop(d);
    chk("t37_drop", 64'(d), 64'd0);

    dut.u_ram.r_mem[17] <= 48'hFFFF_FFFF_FFFF;
    dut.u_ram.r_mem[18] <= 48'h1234_0000_0005;
    tick();
    pulse(5'b10000, 10'h100, 1, 1);
    pulse(5'b10000, 10'h200, 1, 5);
    rd_bin(5'd17, v);
    chk("t38_sat", 64'(v), 64'(SAT_EXP));
    rd(1'b0, 5'd18, 1'b1, w);
    chk("hi_word", 64'(w), 64'h1234);
    rd(1'b0, 5'd18, 1'b0, w);
    chk("lo_word", 64'(w), 64'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
